// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: N-read / 1-write register file with busy scoreboard.
// Sits between decode (reads, issue) and writeback (write, busy clear).
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rs_addr    NRD packed read addresses, port i at [i*AW +: AW]
//   rs_data    NRD packed read data, port i at [i*XLEN +: XLEN]
//   rs_busy    per-port "source has an outstanding producer"
//   we/rd/wd   writeback write port; a write also clears busy[rd]
//   issue_en   marks issue_rd busy at the next edge
//   issue_rd   destination register being issued
//   busy_mask  registered scoreboard, bit r = register r busy
module regfile_scoreboard #(
   parameter  int XLEN     = 32,
   parameter  int NREGS    = 32,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                we,
   input  logic [AW-1:0]       rd,
   input  logic [XLEN-1:0]     wd,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_rd,
   output logic [NREGS-1:0]    busy_mask
);

   localparam logic [AW:0] NR = (AW+1)'(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             w_ok;
   logic             i_ok;

   // In range and not the hardwired zero register.
   function automatic logic writable(input logic [AW-1:0] a);
      return ({1'b0, a} < NR) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign w_ok = we && writable(rd);
   assign i_ok = issue_en && writable(issue_rd);

   // Issue is applied after the clear so a same-register
   // collision leaves the new producer outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else begin
         if (w_ok) begin
            regs[rd] <= wd;
            busy[rd] <= 1'b0;
         end
         if (i_ok) begin
            busy[issue_rd] <= 1'b1;
         end
      end
   end

   assign busy_mask = busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          ok;
      logic          hit;

      assign a   = rs_addr[i*AW +: AW];
      assign ok  = writable(a);
      assign hit = (BYPASS != 0) && w_ok && (rd == a);

      assign rs_data[i*XLEN +: XLEN] = !ok ? '0 :
                                       hit ? wd : regs[a];
      assign rs_busy[i] = ok && !hit && busy[a];
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench.
// Covers default, no-bypass and wide/odd-size configurations.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rs_addr;
   logic [63:0] d0, d1;
   logic [1:0]  b0, b1;
   logic        we;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [31:0] bm0, bm1;

   logic [19:0]  a2;
   logic [255:0] d2;
   logic [3:0]   b2;
   logic         we2;
   logic [4:0]   rd2;
   logic [63:0]  wd2;
   logic         ie2;
   logic [4:0]   ird2;
   logic [23:0]  bm2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_scoreboard u0 (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(d0),
      .rs_busy(b0), .we(we), .rd(rd), .wd(wd), .issue_en(issue_en),
      .issue_rd(issue_rd), .busy_mask(bm0)
   );

   regfile_scoreboard #(.BYPASS(0)) u1 (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(d1),
      .rs_busy(b1), .we(we), .rd(rd), .wd(wd), .issue_en(issue_en),
      .issue_rd(issue_rd), .busy_mask(bm1)
   );

   regfile_scoreboard #(.XLEN(64), .NREGS(24), .NRD(4)) u2 (
      .clk(clk), .rst(rst), .rs_addr(a2), .rs_data(d2),
      .rs_busy(b2), .we(we2), .rd(rd2), .wd(wd2), .issue_en(ie2),
      .issue_rd(ird2), .busy_mask(bm2)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rs_addr = '0; we = 0; rd = '0; wd = '0;
      issue_en = 0; issue_rd = '0;
      a2 = '0; we2 = 0; rd2 = '0; wd2 = '0; ie2 = 0; ird2 = '0;
      step();
      rst = 1'b0;
      rs_addr = {5'd2, 5'd1};
      #1;
      chk("rst_data", d0, 64'h0);
      chk("rst_busy", {62'h0, b0}, 64'h0);
      chk("rst_mask", {32'h0, bm0}, 64'h0);
      chk("rst_mask2", {40'h0, bm2}, 64'h0);

      // T1: fill and mark everything busy, then reset.
      for (int r = 1; r < 32; r++) begin
         we = 1; rd = 5'(r); wd = 32'h1000 + 32'(r);
         issue_en = 1; issue_rd = 5'(r);
         step();
      end
      we = 0; issue_en = 0;
      rs_addr = {5'd31, 5'd4};
      #1;
      chk("t1_fill_data", d0, {32'h101f, 32'h1004});
      chk("t1_fill_mask", {32'h0, bm0}, 64'hffff_fffe);
      chk("t1_fill_busy", {62'h0, b0}, 64'h3);
      rst = 1; we = 1; rd = 5'd3; wd = 32'habcd;
      issue_en = 1; issue_rd = 5'd3;
      step();
      rst = 0; we = 0; issue_en = 0;
      chk("t1_rst_mask", {32'h0, bm0}, 64'h0);
      for (int r = 0; r < 32; r++) begin
         rs_addr = {5'(r), 5'(r)};
         #1;
         chk("t1_rst_data", d0, 64'h0);
      end

      // T2: register zero.
      we = 1; rd = 5'd0; wd = 32'hdeadbeef;
      issue_en = 1; issue_rd = 5'd0; rs_addr = '0;
      #1;
      chk("t2_byp_x0", d0, 64'h0);
      chk("t2_busy_x0", {62'h0, b0}, 64'h0);
      step();
      we = 0; issue_en = 0;
      chk("t2_data_x0", d0, 64'h0);
      chk("t2_mask_x0", {32'h0, bm0}, 64'h0);

      // T3: write-to-read bypass.
      we = 1; rd = 5'd5; wd = 32'h11;
      step();
      wd = 32'h22; rs_addr = {5'd5, 5'd5};
      #1;
      chk("t3_byp_on", d0, {32'h22, 32'h22});
      chk("t3_byp_off", d1, {32'h11, 32'h11});
      step();
      we = 0;
      chk("t3_next_on", d0, {32'h22, 32'h22});
      chk("t3_next_off", d1, {32'h22, 32'h22});

      // T4: issue then write-back.
      issue_en = 1; issue_rd = 5'd7; rs_addr = {5'd5, 5'd7};
      #1;
      chk("t4_issue_hidden", {62'h0, b0}, 64'h0);
      step();
      issue_en = 0;
      chk("t4_busy_on", {62'h0, b0}, 64'h1);
      chk("t4_busy_off", {62'h0, b1}, 64'h1);
      chk("t4_mask", {32'h0, bm0}, 64'h80);
      we = 1; rd = 5'd7; wd = 32'h5;
      #1;
      chk("t4_wb_busy_on", {62'h0, b0}, 64'h0);
      chk("t4_wb_data_on", d0, {32'h22, 32'h5});
      chk("t4_wb_busy_off", {62'h0, b1}, 64'h1);
      chk("t4_wb_data_off", d1, {32'h22, 32'h0});
      step();
      we = 0;
      chk("t4_mask_clr", {32'h0, bm0}, 64'h0);
      chk("t4_data", d1, {32'h22, 32'h5});

      // T5: write and issue collide on a busy register.
      issue_en = 1; issue_rd = 5'd9;
      step();
      we = 1; rd = 5'd9; wd = 32'h99;
      step();
      issue_en = 0; we = 0; rs_addr = {5'd5, 5'd9};
      #1;
      chk("t5_mask_set", {32'h0, bm0}, 64'h200);
      chk("t5_data", d0, {32'h22, 32'h99});
      chk("t5_busy", {62'h0, b0}, 64'h1);
      we = 1; rd = 5'd9; wd = 32'h77;
      step();
      we = 0;
      chk("t5_mask_clr", {32'h0, bm0}, 64'h0);
      chk("t5_ports", d0, {32'h22, 32'h77});

      // T6: XLEN=64, NREGS=24, NRD=4.
      we2 = 1; rd2 = 5'd3; wd2 = 64'h0123_4567_89ab_cdef;
      step();
      rd2 = 5'd23; wd2 = 64'hfedc_ba98_7654_3210;
      step();
      rd2 = 5'd30; wd2 = 64'hffff_ffff_ffff_ffff;
      ie2 = 1; ird2 = 5'd30;
      a2 = {5'd30, 5'd23, 5'd3, 5'd3};
      #1;
      chk("t6_p3_byp", d2[192 +: 64], 64'h0);
      step();
      we2 = 0; ie2 = 0;
      chk("t6_p0", d2[0 +: 64], 64'h0123_4567_89ab_cdef);
      chk("t6_p1", d2[64 +: 64], 64'h0123_4567_89ab_cdef);
      chk("t6_p2", d2[128 +: 64], 64'hfedc_ba98_7654_3210);
      chk("t6_p3", d2[192 +: 64], 64'h0);
      chk("t6_busy", {60'h0, b2}, 64'h0);
      chk("t6_mask", {40'h0, bm2}, 64'h0);
      ie2 = 1; ird2 = 5'd23;
      step();
      ie2 = 0;
      chk("t6_busy23", {60'h0, b2}, 64'h4);
      chk("t6_mask23", {40'h0, bm2}, 64'h80_0000);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
